// File: rtl/bamse_irq_ctrl_pkg.sv
// bamse_irq_ctrl_pkg
//   Shared definitions for the bamse interrupt controller: register offsets,
//   FSM state encoding, VECTOR register layout and the fixed-priority encoder.
//   No ports; imported by the controller and its sub-modules.
package bamse_irq_ctrl_pkg;

    // Register offsets relative to BASE_ADDR.
    localparam logic [1:0] IRQ_STATUS = 2'd0;
    localparam logic [1:0] IRQ_ENABLE = 2'd1;
    localparam logic [1:0] IRQ_CLEAR  = 2'd2;
    localparam logic [1:0] IRQ_VECTOR = 2'd3;

    // VECTOR = {valid, 4'b0, id[2:0]}.
    localparam int         VEC_VALID_BIT = 7;
    localparam logic [7:0] VEC_EMPTY     = 8'h07;  // ack with nothing to serve

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2
    } irq_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] id;
    } prio_t;

    // Lowest set bit wins: index 0 is the highest priority.
    function automatic prio_t prio_lowest(input logic [7:0] req);
        prio_t r;
        r.found = 1'b0;
        r.id    = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                r.found = 1'b1;
                r.id    = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bamse_irq_ctrl_if.sv
// bamse_irq_ctrl_if
//   PacoBlaze3 I/O port bus plus the interrupt/interrupt_ack pair.
//   master : the pblaze side (drives port_id, strobes, out_port, interrupt_ack)
//   slave  : the interrupt controller (drives in_port, interrupt)
interface bamse_irq_ctrl_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        output in_port, interrupt
    );
endinterface

// File: rtl/bamse_irq_debounce.sv
// bamse_irq_debounce
//   One-source debounce filter, compiled only when IRQ_DEBOUNCE_EN is defined.
//   The output level follows din only after din has differed from it for
//   DB_CYCLES consecutive cycles; any bounce restarts the count.
//   Ports: clk, rst (sync, active-high), din (synchronized level), dout (filtered).
`ifdef IRQ_DEBOUNCE_EN
module bamse_irq_debounce #(
    parameter int DB_CYCLES = 32000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int             CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;

    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (din != lvl_q) begin
            // The DB_CYCLES-th consecutive differing cycle commits the new level.
            if (cnt_q == CNT_LAST) lvl_d = din;
            else                   cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign dout = lvl_q;
endmodule
`endif

// File: rtl/bamse_irq_ctrl.sv
// bamse_irq_ctrl
//   Interrupt controller for the bamse PacoBlaze3 SoC. Up to 8 asynchronous
//   sources are synchronized, edge-detected into pending bits and arbitrated
//   (fixed priority, index 0 highest) onto the pblaze interrupt/ack pair.
//   Registers at BASE_ADDR+0..3: STATUS (RO), ENABLE (RW), CLEAR (W1C),
//   VECTOR (RO, write = EOI).
//   Ports: clk, rst (sync, active-high), irq_src[N_SRC] (async sources),
//          bus (bamse_irq_ctrl_if.slave: pblaze port bus + interrupt/ack).
//   Option: define IRQ_DEBOUNCE_EN to insert a bamse_irq_debounce filter per
//           source between the synchronizer and the edge detector.
module bamse_irq_ctrl
    import bamse_irq_ctrl_pkg::*;
#(
    parameter int         N_SRC     = 3,
    parameter logic [7:0] BASE_ADDR = 8'h10,
    parameter int         DB_CYCLES = 32000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  irq_src,
    bamse_irq_ctrl_if.slave   bus
);
    logic [N_SRC-1:0] sync1_q, sync1_d;
    logic [N_SRC-1:0] sync2_q, sync2_d;
    logic [N_SRC-1:0] level;
    logic [N_SRC-1:0] level_q, level_d;
    logic [N_SRC-1:0] edge_q, edge_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] clr_wr, clr_ack;
    logic [7:0]       vector_q;
    logic             irq_q;
    irq_state_e       state_q;

    logic [7:0] offs;
    logic       hit, wr;
    logic [1:0] reg_sel;
    logic       ack_take, eoi;
    prio_t      prio;
    logic [7:0] rdata;
    logic       unused_ok;

    // Subtract-and-compare decode works for any BASE_ADDR, aligned or not.
    assign offs    = bus.port_id - BASE_ADDR;
    assign hit     = (offs < 8'd4);
    assign reg_sel = offs[1:0];
    assign wr      = bus.write_strobe & hit;

    assign ack_take = bus.interrupt_ack && (state_q == S_REQ);
    assign eoi      = wr && (reg_sel == IRQ_VECTOR) && (state_q == S_SVC);
    assign prio     = prio_lowest(8'(pending_q & enable_q));

`ifdef IRQ_DEBOUNCE_EN
    for (genvar i = 0; i < N_SRC; i++) begin : g_db
        bamse_irq_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk  (clk),
            .rst  (rst),
            .din  (sync2_q[i]),
            .dout (level[i])
        );
    end
    assign unused_ok = ^{bus.read_strobe, bus.out_port};
`else
    assign level     = sync2_q;
    assign unused_ok = ^{bus.read_strobe, bus.out_port, 32'(DB_CYCLES)};
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sync1_d  = irq_src;
        sync2_d  = sync1_q;
        level_d  = level;
        edge_d   = level & ~level_q;
        enable_d = enable_q;
        clr_wr   = '0;
        clr_ack  = '0;
        if (wr && reg_sel == IRQ_ENABLE) enable_d = bus.out_port[N_SRC-1:0];
        if (wr && reg_sel == IRQ_CLEAR)  clr_wr   = bus.out_port[N_SRC-1:0];
        if (ack_take && prio.found)      clr_ack  = N_SRC'(1) << prio.id;
        // New edges are OR-ed in after clearing, so a same-cycle set wins.
        pending_d = (pending_q & ~(clr_wr | clr_ack)) | edge_q;
    end

    always_comb begin
        rdata = 8'h00;
        if (hit) begin
            case (reg_sel)
                IRQ_STATUS: rdata = 8'(pending_q);
                IRQ_ENABLE: rdata = 8'(enable_q);
                IRQ_VECTOR: rdata = vector_q;
                default:    rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            edge_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            edge_q    <= edge_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            irq_q    <= 1'b0;
            vector_q <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|(pending_q & enable_q)) begin
                        state_q <= S_REQ;
                        irq_q   <= 1'b1;
                    end
                end
                S_REQ: begin
                    // The request is held until ack even if the masked set empties.
                    if (bus.interrupt_ack) begin
                        state_q  <= S_SVC;
                        irq_q    <= 1'b0;
                        vector_q <= prio.found ? {1'b1, 4'b0000, prio.id} : VEC_EMPTY;
                    end
                end
                S_SVC: begin
                    if (eoi) begin
                        state_q                 <= S_IDLE;
                        vector_q[VEC_VALID_BIT] <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_port   = rdata;
    assign bus.interrupt = irq_q;
endmodule

// File: tb/tb_bamse_irq_ctrl.sv
// tb_bamse_irq_ctrl
//   Self-checking bench for bamse_irq_ctrl (N_SRC=3, BASE_ADDR=8'h10, DB_CYCLES=16).
//   Register access is table-driven; reset, masking, ack/EOI, priority, the
//   set/clear collision, reset-in-service and (with IRQ_DEBOUNCE_EN) debounce
//   are hand-written sequences.
module tb_bamse_irq_ctrl;
    localparam int DB = 16;
`ifdef IRQ_DEBOUNCE_EN
    localparam int LAT_TICKS = 4 + DB;  // edges from source change to pending set
`else
    localparam int LAT_TICKS = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] irq_src = 3'b000;
    int         n_tests = 0;
    int         n_fail  = 0;

    bamse_irq_ctrl_if bus ();

    bamse_irq_ctrl #(
        .N_SRC     (3),
        .BASE_ADDR (8'h10),
        .DB_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .bus     (bus)
    );

    always #15.625 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic [7:0] raddr;
        logic [7:0] exp_rd;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus.port_id      = a;
        bus.out_port     = d;
        bus.write_strobe = 1'b1;
        tick();
        bus.write_strobe = 1'b0;
        bus.port_id      = 8'h00;
        bus.out_port     = 8'h00;
    endtask

    task automatic check_rd(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus.port_id     = a;
        bus.read_strobe = 1'b1;
        #1;
        d = bus.in_port;
        bus.read_strobe = 1'b0;
        bus.port_id     = 8'h00;
        check(name, d, exp);
    endtask

    task automatic pulse_ack();
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
    endtask

    initial begin
        logic irq_seen;

        bus.port_id       = 8'h00;
        bus.write_strobe  = 1'b0;
        bus.read_strobe   = 1'b0;
        bus.out_port      = 8'h00;
        bus.interrupt_ack = 1'b0;

        //           wr    waddr  wdata  raddr  exp_rd irq
        vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h10, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h11, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 8'h13, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 8'h20, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 8'h0F, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'h14, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 8'h11, 8'hFF, 8'h11, 8'h07, 1'b0};  // only 3 enable bits
        vecs[7]  = '{1'b1, 8'h10, 8'hFF, 8'h10, 8'h00, 1'b0};  // STATUS is read-only
        vecs[8]  = '{1'b1, 8'h20, 8'h00, 8'h11, 8'h07, 1'b0};  // out-of-range write ignored
        vecs[9]  = '{1'b1, 8'h13, 8'hFF, 8'h13, 8'h00, 1'b0};  // EOI outside SVC ignored
        vecs[10] = '{1'b1, 8'h11, 8'h05, 8'h11, 8'h05, 1'b0};
        vecs[11] = '{1'b1, 8'h11, 8'h00, 8'h11, 8'h00, 1'b0};

        // 1: reset for 2 cycles, then register file sweep.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset irq", 8'(bus.interrupt), 8'h00);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].waddr, vecs[i].wdata);
            else            tick();
            check_rd($sformatf("vec%0d rd", i), vecs[i].raddr, vecs[i].exp_rd);
            check($sformatf("vec%0d irq", i), 8'(bus.interrupt), 8'(vecs[i].exp_irq));
        end

        // 2: masked event sets STATUS but no interrupt; enabling raises it.
        irq_seen   = 1'b0;
        irq_src[1] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            irq_seen |= bus.interrupt;
        end
        irq_src[1] = 1'b0;
        for (int i = 0; i < LAT_TICKS + 2; i++) begin
            tick();
            irq_seen |= bus.interrupt;
        end
        check("masked irq", 8'(irq_seen), 8'h00);
        check_rd("masked status", 8'h10, 8'h02);
        bus_write(8'h11, 8'h02);
        check("enable +1 irq", 8'(bus.interrupt), 8'h00);
        tick();
        check("enable +2 irq", 8'(bus.interrupt), 8'h01);

        // 3: ack then EOI.
        pulse_ack();
        check("ack irq", 8'(bus.interrupt), 8'h00);
        check_rd("ack vector", 8'h13, 8'h81);
        check_rd("ack status", 8'h10, 8'h00);
        bus_write(8'h13, 8'h00);
        check_rd("eoi vector", 8'h13, 8'h01);
        tick();
        tick();
        check("idle irq", 8'(bus.interrupt), 8'h00);
        pulse_ack();
        check_rd("stray ack vector", 8'h13, 8'h01);

        // 4: priority between src0 and src2 raised together.
        bus_write(8'h11, 8'h07);
        irq_src = 3'b101;
        repeat (LAT_TICKS + 2) tick();
        irq_src = 3'b000;
        check("prio irq", 8'(bus.interrupt), 8'h01);
        pulse_ack();
        check_rd("prio vector1", 8'h13, 8'h80);
        check_rd("prio status1", 8'h10, 8'h04);
        bus_write(8'h13, 8'h00);
        check("prio eoi irq", 8'(bus.interrupt), 8'h00);
        tick();
        check("prio reassert", 8'(bus.interrupt), 8'h01);
        pulse_ack();
        check_rd("prio vector2", 8'h13, 8'h82);
        check_rd("prio status2", 8'h10, 8'h00);
        bus_write(8'h13, 8'h00);
        repeat (40) tick();

        // 5a: CLEAR in the same cycle the edge sets pending: set wins.
        irq_src[0] = 1'b1;
        repeat (LAT_TICKS - 1) tick();
        check_rd("latency status", 8'h10, 8'h00);
        bus_write(8'h12, 8'h01);
        check_rd("collide status", 8'h10, 8'h01);
        tick();
        check("collide irq", 8'(bus.interrupt), 8'h01);
        pulse_ack();
        check_rd("collide vector", 8'h13, 8'h80);

        // 5b: reset while in SVC.
        irq_src = 3'b000;
        rst     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("svc rst irq", 8'(bus.interrupt), 8'h00);
        check_rd("svc rst status", 8'h10, 8'h00);
        check_rd("svc rst enable", 8'h11, 8'h00);
        check_rd("svc rst vector", 8'h13, 8'h00);

`ifdef IRQ_DEBOUNCE_EN
        // 6: bouncing input never passes; steady input passes after DB cycles.
        for (int i = 0; i < 12; i++) begin
            irq_src[0] = ~irq_src[0];
            repeat (5) tick();
        end
        repeat (5) tick();
        check_rd("bounce status", 8'h10, 8'h00);
        irq_src[0] = 1'b1;
        repeat (19) tick();
        check_rd("db early status", 8'h10, 8'h00);
        tick();
        check_rd("db status", 8'h10, 8'h01);
        irq_src[0] = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
